wb_burst_master: RTL and testbench
==================================

WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 The block SHALL have parameters: ADDR_WIDTH, 32, bus address width; DATA_WIDTH, 32, bus data width; MAX_BURST, 16, maximum beats per request; MAX_RETRY, 3, retry attempts (used only with WB_MASTER_RETRY_EN); LEN_W, $clog2(MAX_BURST+1), request length width.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-003 The block SHALL have these ports (name  direction  width  meaning):
- WB_CLK_I  in  1  clock
- WB_RST_I  in  1  asynchronous active-high reset
- WB_ADR_O  out  ADDR_WIDTH  byte address, bits [1:0] forced to 0
- WB_DAT_O  out  DATA_WIDTH  write data
- WB_DAT_I  in  DATA_WIDTH  read data
- WB_WE_O  out  1  write enable
- WB_CTI_O  out  3  cycle type
- WB_STB_O  out  1  strobe
- WB_CYC_O  out  1  cycle
- WB_ACK_I  in  1  normal termination
- WB_ERR_I  in  1  error termination
- WB_RTY_I  in  1  retry termination
- WB_STALL_I  in  1  slave not accepting a beat
- req_valid  in  1  core request
- req_ready  out  1  high only in IDLE
- req_we  in  1  request is a write
- req_addr  in  ADDR_WIDTH  start byte address
- req_len  in  LEN_W  number of beats
- wr_data  in  DATA_WIDTH  head of the first-word-fall-through write source
- wr_pop  out  1  pulse: wr_data consumed by an accepted write beat
- rd_data  out  DATA_WIDTH  read beat data
- rd_valid  out  1  pulse: read beat returned
- done  out  1  one-cycle pulse at request completion
- err  out  1  valid with done; request failed

Function
REQ-004 A request SHALL be accepted when req_valid and req_ready are both high; its fields SHALL be captured on that edge.
REQ-005 The state machine SHALL have the states IDLE, ISSUE, DRAIN, BACKOFF and DONE.
- IDLE -> ISSUE on acceptance.
- ISSUE -> DRAIN when all beats are issued.
- DRAIN -> DONE when all beats are acknowledged.
- Any state -> BACKOFF or DONE on termination error.
- DONE -> IDLE after one cycle.
REQ-006 CYC and STB SHALL be asserted on the cycle after acceptance.
REQ-007 A beat SHALL be issued in each cycle where STB=1 and WB_STALL_I=0; the address SHALL then advance by 4, modulo 2^ADDR_WIDTH.
REQ-008 STB SHALL drop once exactly len beats are issued; CYC SHALL stay high until len ACKs have been counted.
REQ-009 For len=1, CTI SHALL be CLASSIC (000).
REQ-010 For len>1, CTI SHALL be INCR (010) on every beat except the last issued beat, which SHALL be EOB (111).
REQ-011 For a write, WB_DAT_O SHALL equal wr_data and WB_WE_O SHALL be 1; wr_pop SHALL pulse on each issued beat.
REQ-012 For a read, WB_DAT_I SHALL be registered into rd_data, with rd_valid pulsing the cycle after each ACK.
REQ-013 ACKs SHALL be counted independently of issue; an ACK in the same cycle as an issue SHALL update both counters.
REQ-014 With zero stall and ACK one cycle after each beat, a len=N request SHALL pulse done N+2 cycles after acceptance, with CYC low in that same cycle.
REQ-015 req_len=0 SHALL produce a done pulse with err=0 on the cycle after acceptance, with no bus activity.
REQ-016 req_len>MAX_BURST SHALL saturate to MAX_BURST.
REQ-017 ERR SHALL drop CYC and STB on the next cycle, discard the remaining beats, and pulse done with err=1; an ERR arriving with ACK SHALL take priority.
REQ-018 ACK, ERR or RTY received while CYC=0 SHALL be ignored.

Reset
REQ-019 On reset all outputs SHALL be 0 except req_ready, which SHALL be 1.
REQ-020 Reset SHALL force the state to IDLE, zero the counters, and clear the retry count.
REQ-021 Reset asserted mid-burst SHALL drop CYC and STB immediately (asynchronously); no done pulse SHALL be produced for the aborted request.

Configuration
REQ-022 With WB_MASTER_RETRY_EN defined, RTY SHALL drop CYC and STB, wait one BACKOFF cycle, then restart at base+4*acked for len-acked beats with recomputed CTI.
REQ-023 With WB_MASTER_RETRY_EN defined, the (MAX_RETRY+1)th RTY within one request SHALL complete the request with err=1.
REQ-024 Without WB_MASTER_RETRY_EN, RTY SHALL be handled identically to ERR.

Structure
REQ-025 Package wb_pkg SHALL hold the CTI constants (CLASSIC 000, CONST 001, INCR 010, EOB 111) and the master state enum.
REQ-026 No sub-module is required; the block SHALL be a single module.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Read, len=1, addr 0x10; slave returns 0x5 -> CTI=000, one rd_valid with 0x5, done at cycle 3, err=0.
- Write burst, len=4, addr 0x100, data 0xA..0xD -> ADR 0x100/104/108/10C, CTI 010,010,010,111, four wr_pop, done at cycle 6.
- Read burst, len=4, WB_STALL_I high for 2 cycles on beat 2 -> ADR holds at 0x104; four rd_valid in order; done 2 cycles later than unstalled.
- ERR on beat 2 of a len=4 write -> CYC low next cycle, done with err=1, exactly 2 wr_pop.
- RTY on beat 3 of a len=4 read, macro on -> BACKOFF, restart at 0x108 with CTI 010,111, err=0; macro off -> err=1.
- Reset asserted mid-burst -> CYC and STB low immediately, req_ready=1, no done pulse.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: Wishbone cycle-type constants and burst master state encoding
package wb_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, BACKOFF, DONE} state_t;
endpackage

// File: rtl/wb_burst_master.sv
// wb_burst_master: pipelined Wishbone burst master; define WB_MASTER_RETRY_EN to retry on RTY instead of failing
module wb_burst_master
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int MAX_RETRY  = 3,
  parameter int LEN_W      = $clog2(MAX_BURST+1)
) (
  input  logic                  WB_CLK_I,
  input  logic                  WB_RST_I,
  output logic [ADDR_WIDTH-1:0] WB_ADR_O,
  output logic [DATA_WIDTH-1:0] WB_DAT_O,
  input  logic [DATA_WIDTH-1:0] WB_DAT_I,
  output logic                  WB_WE_O,
  output logic [2:0]            WB_CTI_O,
  output logic                  WB_STB_O,
  output logic                  WB_CYC_O,
  input  logic                  WB_ACK_I,
  input  logic                  WB_ERR_I,
  input  logic                  WB_RTY_I,
  input  logic                  WB_STALL_I,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_W-1:0]      req_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  err
);
`ifdef WB_MASTER_RETRY_EN
  localparam int LIM = MAX_RETRY;
`else
  localparam int LIM = MAX_RETRY * 0;
`endif
  localparam int RW = $clog2(MAX_RETRY+2);
  state_t st;
  logic [LEN_W-1:0] len, iss, ackc, seg, iss_n, ack_n, sat;
  logic [ADDR_WIDTH-1:0] base;
  logic [RW-1:0] rc;
  logic we, er, term, ack, issue;
  assign WB_CYC_O  = st == ISSUE || st == DRAIN;
  assign WB_STB_O  = st == ISSUE;
  assign req_ready = st == IDLE;
  assign done      = st == DONE;
  assign err       = done & er;
  assign term      = WB_CYC_O & (WB_ERR_I | WB_RTY_I);
  assign ack       = WB_CYC_O & WB_ACK_I & ~(WB_ERR_I | WB_RTY_I);
  assign issue     = WB_STB_O & ~WB_STALL_I & ~(WB_ERR_I | WB_RTY_I);
  assign wr_pop    = issue & we;
  assign iss_n     = iss + LEN_W'(issue);
  assign ack_n     = ackc + LEN_W'(ack);
  assign sat       = req_len > LEN_W'(MAX_BURST) ? LEN_W'(MAX_BURST) : req_len;
  assign WB_ADR_O  = WB_CYC_O ? base + (ADDR_WIDTH'(iss) << 2) : '0;
  assign WB_WE_O   = WB_CYC_O & we;
  assign WB_DAT_O  = WB_STB_O && we ? wr_data : '0;
  // CTI reflects the current segment, so a restarted tail gets its own INCR/EOB pattern
  always_comb begin
    WB_CTI_O = !WB_STB_O ? CTI_CLASSIC :
               len - seg == LEN_W'(1) ? CTI_CLASSIC :
               iss == len - LEN_W'(1) ? CTI_EOB : CTI_INCR;
  end
  // request FSM with independent issue and acknowledge counters
  always_ff @(posedge WB_CLK_I or posedge WB_RST_I) begin
    if (WB_RST_I) begin
      st <= IDLE;
      len <= '0;
      iss <= '0;
      ackc <= '0;
      seg <= '0;
      base <= '0;
      rc <= '0;
      we <= 1'b0;
      er <= 1'b0;
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= ack & ~we;
      if (ack && !we) rd_data <= WB_DAT_I;
      case (st)
        IDLE: if (req_valid) begin
          len <= sat;
          base <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
          we <= req_we;
          iss <= '0;
          ackc <= '0;
          seg <= '0;
          rc <= '0;
          er <= 1'b0;
          st <= sat == '0 ? DONE : ISSUE;
        end
        ISSUE, DRAIN: begin
          iss <= iss_n;
          ackc <= ack_n;
          if (term && WB_RTY_I && !WB_ERR_I && rc != RW'(LIM)) begin
            rc <= rc + RW'(1);
            iss <= ackc;
            seg <= ackc;
            st <= BACKOFF;
          end else if (term) begin
            er <= 1'b1;
            st <= DONE;
          end else st <= ack_n == len ? DONE : iss_n == len ? DRAIN : ISSUE;
        end
        BACKOFF: st <= ISSUE;
        DONE: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: directed self-checking bench for wb_burst_master
module tb_wb_burst_master;
  logic WB_CLK_I, WB_RST_I;
  logic [31:0] WB_ADR_O, WB_DAT_O, WB_DAT_I, req_addr, wr_data, rd_data;
  logic WB_WE_O, WB_STB_O, WB_CYC_O, WB_ACK_I, WB_ERR_I, WB_RTY_I, WB_STALL_I;
  logic [2:0] WB_CTI_O;
  logic req_valid, req_ready, req_we, wr_pop, rd_valid, done, err;
  logic [4:0] req_len;
  int tests = 0, fails = 0, pops = 0;

  wb_burst_master dut (
    .WB_CLK_I(WB_CLK_I), .WB_RST_I(WB_RST_I), .WB_ADR_O(WB_ADR_O), .WB_DAT_O(WB_DAT_O),
    .WB_DAT_I(WB_DAT_I), .WB_WE_O(WB_WE_O), .WB_CTI_O(WB_CTI_O), .WB_STB_O(WB_STB_O),
    .WB_CYC_O(WB_CYC_O), .WB_ACK_I(WB_ACK_I), .WB_ERR_I(WB_ERR_I), .WB_RTY_I(WB_RTY_I),
    .WB_STALL_I(WB_STALL_I), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data), .wr_pop(wr_pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err)
  );

  initial WB_CLK_I = 0;
  always #5 WB_CLK_I = ~WB_CLK_I;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic a, input logic e, input logic r, input logic s, input logic [31:0] d);
    @(negedge WB_CLK_I);
    req_valid = 0;
    WB_ACK_I = a;
    WB_ERR_I = e;
    WB_RTY_I = r;
    WB_STALL_I = s;
    WB_DAT_I = d;
    wr_data = d;
    #1;
    if (wr_pop) pops++;
  endtask

  task automatic start(input logic w, input logic [31:0] a, input logic [4:0] l);
    @(negedge WB_CLK_I);
    req_valid = 1;
    req_we = w;
    req_addr = a;
    req_len = l;
    WB_ACK_I = 0;
    WB_ERR_I = 0;
    WB_RTY_I = 0;
    WB_STALL_I = 0;
    pops = 0;
    #1;
    chk("req_ready", req_ready, 1);
  endtask

  initial begin
    WB_RST_I = 1;
    req_valid = 0; req_we = 0; req_addr = 0; req_len = 0;
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_bus", {WB_CYC_O, WB_STB_O, WB_WE_O, WB_CTI_O, wr_pop, rd_valid, done, err}, 0);
    chk("rst_adr", WB_ADR_O, 0);
    chk("rst_rdata", rd_data, 0);
    WB_RST_I = 0;

    start(0, 32'h10, 1);
    tick(0, 0, 0, 0, 0);
    chk("r1_c1_bus", {WB_CYC_O, WB_STB_O, WB_WE_O}, 3'b110);
    chk("r1_adr", WB_ADR_O, 32'h10);
    chk("r1_cti", WB_CTI_O, 0);
    tick(1, 0, 0, 0, 5);
    chk("r1_c2_bus", {WB_CYC_O, WB_STB_O, done}, 3'b100);
    tick(0, 0, 0, 0, 0);
    chk("r1_c3_done", {done, err, WB_CYC_O, rd_valid}, 4'b1001);
    chk("r1_rdata", rd_data, 5);
    tick(0, 0, 0, 0, 0);
    chk("r1_c4", {done, rd_valid, req_ready}, 3'b001);

    start(1, 32'h100, 4);
    for (int c = 1; c <= 4; c++) begin
      tick(c > 1, 0, 0, 0, 32'h9 + c);
      chk("w4_adr", WB_ADR_O, 32'h100 + 4 * (c - 1));
      chk("w4_cti", WB_CTI_O, c == 4 ? 3'b111 : 3'b010);
      chk("w4_dat", WB_DAT_O, 32'h9 + c);
      chk("w4_we_pop", {WB_WE_O, wr_pop}, 2'b11);
    end
    tick(1, 0, 0, 0, 0);
    chk("w4_c5", {WB_CYC_O, WB_STB_O, wr_pop, done}, 4'b1000);
    tick(0, 0, 0, 0, 0);
    chk("w4_c6_done", {done, err, WB_CYC_O}, 3'b100);
    chk("w4_pops", pops, 4);

    start(0, 32'h100, 4);
    tick(0, 0, 0, 0, 0);
    chk("s4_c1_adr", WB_ADR_O, 32'h100);
    tick(1, 0, 0, 1, 32'h11);
    chk("s4_c2_adr", WB_ADR_O, 32'h104);
    tick(0, 0, 0, 1, 0);
    chk("s4_c3_adr", WB_ADR_O, 32'h104);
    chk("s4_c3_rd", {rd_valid, rd_data}, {1'b1, 32'h11});
    tick(0, 0, 0, 0, 0);
    chk("s4_c4_adr", WB_ADR_O, 32'h104);
    chk("s4_c4_cti_rv", {WB_CTI_O, rd_valid}, 4'b0100);
    tick(1, 0, 0, 0, 32'h22);
    chk("s4_c5_adr", WB_ADR_O, 32'h108);
    tick(1, 0, 0, 0, 32'h33);
    chk("s4_c6_adr", WB_ADR_O, 32'h10C);
    chk("s4_c6_cti", WB_CTI_O, 3'b111);
    chk("s4_c6_rd", {rd_valid, rd_data}, {1'b1, 32'h22});
    tick(1, 0, 0, 0, 32'h44);
    chk("s4_c7_bus", {WB_CYC_O, WB_STB_O, done}, 3'b100);
    chk("s4_c7_rd", {rd_valid, rd_data}, {1'b1, 32'h33});
    tick(0, 0, 0, 0, 0);
    chk("s4_c8_done", {done, err, WB_CYC_O}, 3'b100);
    chk("s4_c8_rd", {rd_valid, rd_data}, {1'b1, 32'h44});

    start(1, 32'h200, 4);
    tick(0, 0, 0, 0, 32'hA);
    tick(1, 0, 0, 0, 32'hB);
    tick(1, 1, 0, 0, 32'hC);
    chk("e4_c3", {WB_CYC_O, WB_STB_O, wr_pop}, 3'b110);
    tick(0, 0, 0, 0, 0);
    chk("e4_c4_done", {done, err, WB_CYC_O, WB_STB_O}, 4'b1100);
    chk("e4_pops", pops, 2);

    start(0, 32'h100, 4);
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 32'h11);
    tick(1, 0, 0, 0, 32'h22);
    chk("y4_c3_adr", WB_ADR_O, 32'h108);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
`ifdef WB_MASTER_RETRY_EN
    chk("y4_backoff", {WB_CYC_O, WB_STB_O, done}, 3'b000);
    tick(0, 0, 0, 0, 0);
    chk("y4_re_adr0", WB_ADR_O, 32'h108);
    chk("y4_re_cti0", WB_CTI_O, 3'b010);
    tick(1, 0, 0, 0, 32'h33);
    chk("y4_re_adr1", WB_ADR_O, 32'h10C);
    chk("y4_re_cti1", WB_CTI_O, 3'b111);
    tick(1, 0, 0, 0, 32'h44);
    chk("y4_drain", {WB_CYC_O, WB_STB_O}, 2'b10);
    tick(0, 0, 0, 0, 0);
    chk("y4_done", {done, err, WB_CYC_O}, 3'b100);
    chk("y4_rd", rd_data, 32'h44);
`else
    chk("y4_done", {done, err, WB_CYC_O, WB_STB_O}, 4'b1100);
`endif

    start(0, 32'h40, 0);
    tick(0, 0, 0, 0, 0);
    chk("z_done", {done, err, WB_CYC_O, WB_STB_O}, 4'b1000);

    tick(1, 1, 1, 0, 32'h77);
    chk("idle_ign", {done, err, WB_CYC_O, req_ready}, 4'b0001);
    tick(0, 0, 0, 0, 0);
    chk("idle_ign_rv", rd_valid, 0);

    start(1, 32'h0, 20);
    for (int c = 1; c <= 18; c++) begin
      tick(c >= 2 && c <= 17, 0, 0, 0, 32'(c));
      if (c == 16) chk("sat_eob", WB_CTI_O, 3'b111);
      if (c == 17) chk("sat_nodone", {done, WB_STB_O}, 2'b00);
    end
    chk("sat_done", {done, err}, 2'b10);
    chk("sat_pops", pops, 16);

    start(0, 32'h300, 4);
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 1);
    #2;
    WB_RST_I = 1;
    #1;
    chk("mrst_bus", {WB_CYC_O, WB_STB_O}, 2'b00);
    chk("mrst_ready", req_ready, 1);
    tick(1, 0, 0, 0, 0);
    WB_RST_I = 0;
    for (int c = 0; c < 4; c++) begin
      tick(1, 0, 0, 0, 0);
      chk("mrst_nodone", {done, WB_CYC_O}, 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
